vote_tally: RTL and testbench

- Parametrised successor to the fixed 4-candidate vote counter for the voting machine datapath.
- Counts one-hot votes for NUM_CAND candidates with saturating counters and rejects malformed (multi-hot) inputs.
- In result mode, runs a sequential scan that reports the winner, the winning count and a tie flag to the display/result logic.

---
 rtl/vote_pkg.sv | 27 ++
 rtl/vote_max_scan.sv | 89 ++++++++
 rtl/vote_tally.sv | 95 +++++++++
 tb/tb_vote_tally.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally datapath: FSM states, vote-pattern
// classification and a width-generic saturating increment.
package vote_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {VOTE, SCAN, DONE} state_t;
    typedef enum logic [1:0] {VV_NONE, VV_ONE, VV_MULTI} vv_class_t;

    // v & (v-1) clears the lowest set bit, so a non-zero result means two or more bits set.
    function automatic vv_class_t classify_vote(input logic [MAX_W-1:0] v);
        if (v == '0)
            return VV_NONE;
        else if ((v & (v - MAX_W'(1))) == '0)
            return VV_ONE;
        else
            return VV_MULTI;
    endfunction

    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] val,
                                                 input int unsigned     w);
        logic [MAX_W-1:0] lim;
        lim = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return (val >= lim) ? val : val + MAX_W'(1);
    endfunction

endpackage

// File: rtl/vote_max_scan.sv
// Sequential max search over the frozen candidate counters: one candidate per cycle,
// lowest index wins ties, and the tie flag reports any equal competitor.
module vote_max_scan
    import vote_pkg::*;
#(
    parameter  int NUM_CAND = 4,
    parameter  int CNT_W    = 32,
    localparam int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_CAND*CNT_W-1:0] cnt_bus,
    output state_t                    state,
    output logic                      result_valid,
    output logic [IDX_W-1:0]          winner_idx,
    output logic [CNT_W-1:0]          winner_cnt,
    output logic                      tie
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND - 1);

    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nidx;
    logic [CNT_W-1:0] cand;

    assign nidx = idx + IDX_W'(1);
    assign cand = cnt_bus[nidx*CNT_W +: CNT_W];

    always_comb begin
        state_nxt = state;
        case (state)
            VOTE:    if (start) state_nxt = SCAN;
            SCAN: begin
                if (abort)
                    state_nxt = VOTE;
                else if (idx == LAST)
                    state_nxt = DONE;
            end
            DONE:    if (abort) state_nxt = VOTE;
            default: state_nxt = VOTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= VOTE;
        else
            state <= state_nxt;
    end

    // idx is the last candidate already folded into the running best.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            winner_idx <= '0;
            winner_cnt <= '0;
            tie        <= 1'b0;
        end else begin
            case (state)
                VOTE: begin
                    if (start) begin
                        idx        <= '0;
                        winner_idx <= '0;
                        winner_cnt <= cnt_bus[CNT_W-1:0];
                        tie        <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!abort && idx != LAST) begin
                        idx <= nidx;
                        if (cand > winner_cnt) begin
                            winner_idx <= nidx;
                            winner_cnt <= cand;
                            tie        <= 1'b0;
                        end else if (cand == winner_cnt) begin
                            tie <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_valid = (state == DONE);

endmodule

// File: rtl/vote_tally.sv
// Saturating one-hot vote counter with multi-hot rejection and a sequential winner scan.
// Optional one-vote-per-press lockout is enabled by defining VOTE_TALLY_LOCKOUT_EN.
module vote_tally
    import vote_pkg::*;
#(
    parameter  int NUM_CAND = 4,
    parameter  int CNT_W    = 32,
    localparam int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [NUM_CAND-1:0]       vote_valid,
    output logic [NUM_CAND*CNT_W-1:0] cand_vote_rcvd,
    output logic [CNT_W-1:0]          total_votes,
    output logic [CNT_W-1:0]          reject_cnt,
    output logic                      vote_ack,
    output logic                      result_valid,
    output logic [IDX_W-1:0]          winner_idx,
    output logic [CNT_W-1:0]          winner_cnt,
    output logic                      tie
);
    state_t           state;
    vv_class_t        vclass;
    logic             voting;
    logic             accept;
    logic             reject;
    logic             locked;
    logic [CNT_W-1:0] cnt [NUM_CAND];

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(MAX_W'(v), CNT_W));
    endfunction

    assign vclass = classify_vote(MAX_W'(vote_valid));
    assign voting = (state == VOTE) && !mode && !locked;
    assign accept = voting && (vclass == VV_ONE);
    assign reject = voting && (vclass == VV_MULTI);

`ifdef VOTE_TALLY_LOCKOUT_EN
    // A held button counts once; an idle cycle re-arms voting.
    always_ff @(posedge clk) begin
        if (reset)
            locked <= 1'b0;
        else if (accept)
            locked <= 1'b1;
        else if (vote_valid == '0)
            locked <= 1'b0;
    end
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++)
                cnt[i] <= '0;
            total_votes <= '0;
            reject_cnt  <= '0;
            vote_ack    <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_CAND; i++)
                    if (vote_valid[i])
                        cnt[i] <= sat_cnt(cnt[i]);
                total_votes <= sat_cnt(total_votes);
            end
            if (reject)
                reject_cnt <= sat_cnt(reject_cnt);
            vote_ack <= accept;
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_flat
        assign cand_vote_rcvd[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Counters cannot move outside VOTE, so the scan sees a frozen bus.
    vote_max_scan #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_scan (
        .clk          (clk),
        .reset        (reset),
        .start        (mode),
        .abort        (!mode),
        .cnt_bus      (cand_vote_rcvd),
        .state        (state),
        .result_valid (result_valid),
        .winner_idx   (winner_idx),
        .winner_cnt   (winner_cnt),
        .tie          (tie)
    );

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: a 32-bit and a 4-bit instance share stimulus and
// are compared against an arithmetic model of the vote/result rules.
module tb_vote_tally;
    localparam int N    = 4;
    localparam int CW   = 32;
    localparam int CWS  = 4;
    localparam longint unsigned WMAX = 64'hFFFF_FFFF;
    localparam longint unsigned SMAX = 64'd15;
`ifdef VOTE_TALLY_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic mode;
    logic [N-1:0] vote_valid;

    logic [N*CW-1:0]  cand_w;
    logic [CW-1:0]    total_w, rej_w, wcnt_w;
    logic             ack_w, rv_w, tie_w;
    logic [1:0]       widx_w;
    logic [N*CWS-1:0] cand_s;
    logic [CWS-1:0]   total_s, rej_s, wcnt_s;
    logic             ack_s, rv_s, tie_s;
    logic [1:0]       widx_s;

    always #5 clk = ~clk;

    vote_tally #(.NUM_CAND(N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .vote_valid(vote_valid),
        .cand_vote_rcvd(cand_w), .total_votes(total_w), .reject_cnt(rej_w),
        .vote_ack(ack_w), .result_valid(rv_w), .winner_idx(widx_w),
        .winner_cnt(wcnt_w), .tie(tie_w)
    );

    vote_tally #(.NUM_CAND(N), .CNT_W(CWS)) dut_s (
        .clk(clk), .reset(reset), .mode(mode), .vote_valid(vote_valid),
        .cand_vote_rcvd(cand_s), .total_votes(total_s), .reject_cnt(rej_s),
        .vote_ack(ack_s), .result_valid(rv_s), .winner_idx(widx_s),
        .winner_cnt(wcnt_s), .tie(tie_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: unbounded counts, clipped to each instance's range when compared.
    longint unsigned m_cnt [N];
    longint unsigned m_total, m_rej;
    bit m_lock, prev_mode, exp_ack, exp_rv;
    int run_len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned clip(input longint unsigned x, input longint unsigned lim);
        return (x > lim) ? lim : x;
    endfunction

    function automatic void winner(input longint unsigned lim, output int idx,
                                   output longint unsigned best, output bit t);
        int hits;
        best = 0;
        for (int i = 0; i < N; i++)
            if (clip(m_cnt[i], lim) > best) best = clip(m_cnt[i], lim);
        idx  = -1;
        hits = 0;
        for (int i = 0; i < N; i++) begin
            if (clip(m_cnt[i], lim) == best) begin
                hits++;
                if (idx < 0) idx = i;
            end
        end
        t = (hits > 1);
    endfunction

    // The FSM is in VOTE at an edge exactly when the previous edge sampled mode = 0.
    task automatic model_edge(input bit r);
        exp_ack = 1'b0;
        if (r) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_total = 0; m_rej = 0; m_lock = 0; prev_mode = 0; run_len = 0;
        end else begin
            if (!prev_mode && !mode && !m_lock) begin
                if ($countones(vote_valid) == 1) begin
                    for (int i = 0; i < N; i++) if (vote_valid[i]) m_cnt[i]++;
                    m_total++;
                    exp_ack = 1'b1;
                    m_lock  = LOCK;
                end else if ($countones(vote_valid) >= 2) begin
                    m_rej++;
                end
            end
            if (vote_valid == '0) m_lock = 1'b0;
            run_len   = mode ? run_len + 1 : 0;
            prev_mode = mode;
        end
        exp_rv = (run_len >= N + 1);
    endtask

    task automatic check_all();
        int wi;
        longint unsigned wc;
        bit wt;
        check("ack", 64'(ack_w), 64'(exp_ack));
        check("ack_s", 64'(ack_s), 64'(exp_ack));
        check("result_valid", 64'(rv_w), 64'(exp_rv));
        check("result_valid_s", 64'(rv_s), 64'(exp_rv));
        for (int i = 0; i < N; i++) begin
            check($sformatf("cand%0d", i), 64'(cand_w[i*CW +: CW]), clip(m_cnt[i], WMAX));
            check($sformatf("cand%0d_s", i), 64'(cand_s[i*CWS +: CWS]), clip(m_cnt[i], SMAX));
        end
        check("total", 64'(total_w), clip(m_total, WMAX));
        check("total_s", 64'(total_s), clip(m_total, SMAX));
        check("reject", 64'(rej_w), clip(m_rej, WMAX));
        check("reject_s", 64'(rej_s), clip(m_rej, SMAX));
        if (exp_rv) begin
            winner(WMAX, wi, wc, wt);
            check("winner_idx", 64'(widx_w), 64'(wi));
            check("winner_cnt", 64'(wcnt_w), wc);
            check("tie", 64'(tie_w), 64'(wt));
            winner(SMAX, wi, wc, wt);
            check("winner_idx_s", 64'(widx_s), 64'(wi));
            check("winner_cnt_s", 64'(wcnt_s), wc);
            check("tie_s", 64'(tie_s), 64'(wt));
        end
    endtask

    task automatic step(input bit m, input logic [N-1:0] v, input bit r = 1'b0);
        mode = m; vote_valid = v; reset = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_all();
    endtask

    task automatic vote_n(input int c, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, N'(1) << c);
            step(1'b0, '0);
        end
    endtask

    int acks;
    bit rm;
    logic [N-1:0] rv;
    int rsel;

    initial begin
        reset = 1'b1; mode = 1'b0; vote_valid = '0;
        @(negedge clk);
        step(0, '0, 1); step(0, '0, 1);
        check("rst_widx", 64'(widx_w), 64'(0));
        check("rst_wcnt", 64'(wcnt_w), 64'(0));
        check("rst_tie", 64'(tie_w), 64'(0));
        check("rst_wcnt_s", 64'(wcnt_s), 64'(0));

        // Basic counting: 0001 x3 then 0100.
        acks = 0;
        for (int k = 0; k < 3; k++) begin step(0, 4'b0001); acks += int'(ack_w); end
        step(0, 4'b0100); acks += int'(ack_w);
        step(0, '0);      acks += int'(ack_w);
        check("tp1_cand0", 64'(cand_w[0 +: CW]), LOCK ? 64'(1) : 64'(3));
        check("tp1_cand2", 64'(cand_w[2*CW +: CW]), LOCK ? 64'(0) : 64'(1));
        check("tp1_total", 64'(total_w), LOCK ? 64'(1) : 64'(4));
        check("tp1_acks", 64'(acks), LOCK ? 64'(1) : 64'(4));

        // Multi-hot reject.
        step(0, 4'b0011);
        check("tp2_ack", 64'(ack_w), 64'(0));
        step(0, '0);
        check("tp2_reject", 64'(rej_w), 64'(1));

        // Counts {5,9,2,9}, then scan.
        step(0, '0, 1);
        vote_n(0, 5); vote_n(1, 9); vote_n(2, 2); vote_n(3, 9);
        for (int k = 0; k < 4; k++) step(1, '0);
        check("tp3_not_yet", 64'(rv_w), 64'(0));
        step(1, '0);
        check("tp3_valid", 64'(rv_w), 64'(1));
        check("tp3_idx", 64'(widx_w), 64'(1));
        check("tp3_cnt", 64'(wcnt_w), 64'(9));
        check("tp3_tie", 64'(tie_w), 64'(1));
        step(1, 4'b0001); step(1, '0);
        step(0, '0);

        // Aborted scan, then a vote for candidate 3.
        step(1, '0); step(1, '0);
        step(0, 4'b1000); step(0, 4'b1000); step(0, '0);
        check("tp5_cand3", 64'(cand_w[3*CW +: CW]), 64'(10));

        // All-zero counters after reset.
        step(0, '0, 1);
        for (int k = 0; k < 5; k++) step(1, '0);
        check("zero_idx", 64'(widx_w), 64'(0));
        check("zero_cnt", 64'(wcnt_w), 64'(0));
        check("zero_tie", 64'(tie_w), 64'(1));
        step(0, '0);

        // Reset in the middle of a scan.
        step(1, '0); step(1, '0);
        step(1, '0, 1);
        check("midscan_rv", 64'(rv_w), 64'(0));
        for (int k = 0; k < 5; k++) step(1, '0);
        step(0, '0);

        // Saturation on the 4-bit instance.
        step(0, '0, 1);
        vote_n(0, 17);
        check("sat_cand0_s", 64'(cand_s[0 +: CWS]), 64'(15));
        check("sat_total_s", 64'(total_s), 64'(15));
        check("sat_cand0", 64'(cand_w[0 +: CW]), 64'(17));

        // Held button.
        step(0, '0, 1);
        for (int k = 0; k < 5; k++) step(0, 4'b0010);
        step(0, '0); step(0, 4'b0010); step(0, '0);
        check("hold_cand1", 64'(cand_w[1*CW +: CW]), LOCK ? 64'(2) : 64'(6));

        // Randomized traffic.
        step(0, '0, 1);
        rm = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 9) == 0) rm = ~rm;
            rsel = $urandom_range(0, 9);
            if (rsel < 3)      rv = '0;
            else if (rsel < 7) rv = N'(1) << $urandom_range(0, N - 1);
            else               rv = N'($urandom);
            step(rm, rv, ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
